// File: rtl/pipe_pkg.sv
// Shared types for the 5-stage pipeline hazard/forwarding controller.
// Slot address fields are sized for the widest supported register address.
package pipe_pkg;

  localparam int AW_MAX = 8;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    HZ_RUN  = 1'b0,
    HZ_HALT = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic              v;
    logic [AW_MAX-1:0] dst;
    logic              wr;
    logic              mrd;
  } slot_t;

  // EXE additionally remembers its sources so later stages can forward into it
  typedef struct packed {
    slot_t             s;
    logic [AW_MAX-1:0] rs;
    logic [AW_MAX-1:0] rt;
  } exe_slot_t;

  function automatic fwd_sel_e pick_fwd(input logic mem_hit, input logic wb_hit);
    if (mem_hit) return FWD_MEM;
    if (wb_hit)  return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hz_match.sv
// Compares one pipeline slot's destination against one source register.
// r0 is hard-wired to zero, so it never produces a hit.
module hz_match #(
  parameter int AW = 5
) (
  input  logic          valid,
  input  logic          wr,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] src,
  input  logic          used,
  output logic          hit
);

  assign hit = valid & wr & used & (dst != '0) & (dst == src);

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller: shadow EXE/MEM/WB scoreboard driving stalls,
// flushes and EXE operand forwarding, plus a RUN/HALT exception mode.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int AW     = 5,
  parameter bit FWD_EN = 1'b1,
  parameter bit RF_WT  = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [AW-1:0] id_dst,
  input  logic          id_reg_wr,
  input  logic          id_mem_rd,
  input  logic          id_jump,
  input  logic          br_taken_mem,
  input  logic          exc_ex,
  input  logic          exc_clear,
  output logic          stall_pc,
  output logic          stall_if_id,
  output logic          bubble_id_ex,
  output logic          flush_if_id,
  output logic          flush_id_ex,
  output logic          flush_ex_mem,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          halted
);

  exe_slot_t         exe_q;
  exe_slot_t         id_slot;
  slot_t             mem_q;
  slot_t             wb_q;
  slot_t             chk [3];
  hz_state_e         state_q;
  hz_state_e         state_d;
  logic [AW_MAX-1:0] src_rs;
  logic [AW_MAX-1:0] src_rt;
  logic [2:0]        rs_hit;
  logic [2:0]        rt_hit;
  logic [1:0]        fa_hit;
  logic [1:0]        fb_hit;
  logic              exe_hit;
  logic              mem_hit;
  logic              wb_hit;
  logic              raw;
  logic              in_run;
  logic              stall;
  logic              br_flush;
  logic              take_exc;
  logic              mem_kill;
  logic              exe_kill;
  logic              unused_bits;

  assign src_rs = AW_MAX'(id_rs);
  assign src_rt = AW_MAX'(id_rt);
  assign chk[0] = exe_q.s;
  assign chk[1] = mem_q;
  assign chk[2] = wb_q;

  for (genvar s = 0; s < 3; s++) begin : g_id
    hz_match #(.AW(AW_MAX)) u_rs (
      .valid(chk[s].v), .wr(chk[s].wr), .dst(chk[s].dst),
      .src(src_rs), .used(id_use_rs), .hit(rs_hit[s])
    );
    hz_match #(.AW(AW_MAX)) u_rt (
      .valid(chk[s].v), .wr(chk[s].wr), .dst(chk[s].dst),
      .src(src_rt), .used(id_use_rt), .hit(rt_hit[s])
    );
  end

  // Unused EXE sources were stored as r0, so "used" is implied by the r0 rule
  for (genvar f = 0; f < 2; f++) begin : g_fwd
    hz_match #(.AW(AW_MAX)) u_a (
      .valid(chk[f+1].v), .wr(chk[f+1].wr), .dst(chk[f+1].dst),
      .src(exe_q.rs), .used(1'b1), .hit(fa_hit[f])
    );
    hz_match #(.AW(AW_MAX)) u_b (
      .valid(chk[f+1].v), .wr(chk[f+1].wr), .dst(chk[f+1].dst),
      .src(exe_q.rt), .used(1'b1), .hit(fb_hit[f])
    );
  end

  assign exe_hit = rs_hit[0] | rt_hit[0];
  assign mem_hit = rs_hit[1] | rt_hit[1];
  assign wb_hit  = rs_hit[2] | rt_hit[2];

  always_comb begin
    raw = 1'b0;
    if (FWD_EN) raw = exe_hit & exe_q.s.mrd;
    else        raw = exe_hit | mem_hit;
    if (!RF_WT) raw = raw | wb_hit;
  end

  assign in_run   = (state_q == HZ_RUN);
  assign br_flush = in_run & br_taken_mem;
  assign stall    = in_run & ~br_taken_mem & raw;
  assign take_exc = in_run & exc_ex & exe_q.s.v & ~br_taken_mem;
  assign mem_kill = br_flush | take_exc;
  assign exe_kill = ~in_run | stall | br_flush | ~id_valid;

  always_comb begin
    id_slot       = '0;
    id_slot.s.v   = 1'b1;
    id_slot.s.dst = AW_MAX'(id_dst);
    id_slot.s.wr  = id_reg_wr;
    id_slot.s.mrd = id_mem_rd;
    id_slot.rs    = id_use_rs ? src_rs : '0;
    id_slot.rt    = id_use_rt ? src_rt : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= HZ_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    fwd_a        = FWD_REG;
    fwd_b        = FWD_REG;
    halted       = 1'b0;

    unique case (state_q)
      HZ_RUN:  if (take_exc)  state_d = HZ_HALT;
      HZ_HALT: if (exc_clear) state_d = HZ_RUN;
      default: state_d = HZ_RUN;
    endcase

    // Reset masks every output; a taken branch outranks stall, jump and exception
    if (!reset) begin
      if (state_q == HZ_HALT) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
        halted       = 1'b1;
      end else begin
        if (br_taken_mem) begin
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
        end else begin
          stall_pc     = stall;
          stall_if_id  = stall;
          bubble_id_ex = stall;
          flush_if_id  = id_jump & id_valid & ~stall;
          flush_ex_mem = take_exc;
        end
        if (FWD_EN) begin
          fwd_a = pick_fwd(fa_hit[0], fa_hit[1]);
          fwd_b = pick_fwd(fb_hit[0], fb_hit[1]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exe_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= mem_kill ? '0 : exe_q.s;
      exe_q <= exe_kill ? '0 : id_slot;
    end
  end

  assign unused_bits = ^{wb_q.mrd, mem_q.mrd, mem_hit, wb_hit, fa_hit, fb_hit};

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: three parameter configurations driven in lockstep,
// directed scenarios followed by random traffic against an instruction-level model.
module tb_pipe_hazard_unit;

  localparam int         AW      = 5;
  localparam int         NCFG    = 3;
  localparam logic [2:0] CFG_FWD = 3'b001;
  localparam logic [2:0] CFG_RT  = 3'b100;

  typedef struct {
    bit v;
    int dst;
    bit wr;
    bit mrd;
    int rs;
    int rt;
    bit use_rs;
    bit use_rt;
  } instr_t;

  typedef struct packed {
    logic       spc;
    logic       sif;
    logic       bub;
    logic       fif;
    logic       fie;
    logic       fem;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       hlt;
  } out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, id_valid, id_use_rs, id_use_rt, id_reg_wr, id_mem_rd;
  logic          id_jump, br_taken_mem, exc_ex, exc_clear;
  logic [AW-1:0] id_rs, id_rt, id_dst;
  logic [NCFG-1:0] stall_pc, stall_if_id, bubble_id_ex;
  logic [NCFG-1:0] flush_if_id, flush_id_ex, flush_ex_mem, halted;
  logic [1:0]      fwd_a [NCFG];
  logic [1:0]      fwd_b [NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    pipe_hazard_unit #(.AW(AW), .FWD_EN(CFG_FWD[g]), .RF_WT(CFG_RT[g])) u_dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_dst(id_dst), .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd),
      .id_jump(id_jump), .br_taken_mem(br_taken_mem), .exc_ex(exc_ex),
      .exc_clear(exc_clear), .stall_pc(stall_pc[g]), .stall_if_id(stall_if_id[g]),
      .bubble_id_ex(bubble_id_ex[g]), .flush_if_id(flush_if_id[g]),
      .flush_id_ex(flush_id_ex[g]), .flush_ex_mem(flush_ex_mem[g]),
      .fwd_a(fwd_a[g]), .fwd_b(fwd_b[g]), .halted(halted[g])
    );
  end

  int     tests_run = 0;
  int     tests_failed = 0;
  int     cyc = 0;
  instr_t pipe [NCFG][3];
  bit     in_halt [NCFG];
  out_t   obs [NCFG];
  int     nstall [NCFG];

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic instr_t empty_instr();
    instr_t e;
    e = '{v:0, dst:0, wr:0, mrd:0, rs:0, rt:0, use_rs:0, use_rt:0};
    return e;
  endfunction

  function automatic bit writes(instr_t p, int r, bit used);
    return used && p.v && p.wr && r != 0 && p.dst == r;
  endfunction

  function automatic logic [1:0] src_sel(int c, int r, bit used);
    if (writes(pipe[c][1], r, used)) return 2'b01;
    if (writes(pipe[c][2], r, used)) return 2'b10;
    return 2'b00;
  endfunction

  // Expected outputs derived from the in-flight instructions (index 0=EXE, 1=MEM, 2=WB)
  function automatic out_t model_out(int c);
    out_t o;
    bit   need;
    o = '0;
    need = 1'b0;
    if (reset) return o;
    if (in_halt[c]) begin
      o.spc = 1; o.sif = 1; o.bub = 1; o.hlt = 1;
      return o;
    end
    for (int k = 0; k < 3; k++) begin
      if (writes(pipe[c][k], int'(id_rs), id_use_rs) || writes(pipe[c][k], int'(id_rt), id_use_rt)) begin
        if (k == 0 && (!CFG_FWD[c] || pipe[c][0].mrd)) need = 1'b1;
        if (k == 1 && !CFG_FWD[c]) need = 1'b1;
        if (k == 2 && !CFG_RT[c]) need = 1'b1;
      end
    end
    if (br_taken_mem) begin
      o.fif = 1; o.fie = 1; o.fem = 1;
    end else begin
      o.spc = need; o.sif = need; o.bub = need;
      o.fif = id_jump && id_valid && !need;
      o.fem = exc_ex && pipe[c][0].v;
    end
    if (CFG_FWD[c]) begin
      o.fa = src_sel(c, pipe[c][0].rs, pipe[c][0].use_rs);
      o.fb = src_sel(c, pipe[c][0].rt, pipe[c][0].use_rt);
    end
    return o;
  endfunction

  function automatic void model_step(int c, out_t o);
    instr_t nw;
    bit     exe_v;
    if (reset) begin
      for (int k = 0; k < 3; k++) pipe[c][k] = empty_instr();
      in_halt[c] = 1'b0;
      return;
    end
    exe_v = pipe[c][0].v;
    nw = '{v:1, dst:int'(id_dst), wr:id_reg_wr, mrd:id_mem_rd, rs:int'(id_rs),
           rt:int'(id_rt), use_rs:id_use_rs, use_rt:id_use_rt};
    pipe[c][2] = pipe[c][1];
    pipe[c][1] = o.fem ? empty_instr() : pipe[c][0];
    pipe[c][0] = (o.bub || o.fie || in_halt[c] || !id_valid) ? empty_instr() : nw;
    if (!in_halt[c] && exc_ex && exe_v && !br_taken_mem) in_halt[c] = 1'b1;
    else if (in_halt[c] && exc_clear) in_halt[c] = 1'b0;
  endfunction

  // Called just after a falling edge with inputs already driven
  task automatic apply_stimulus();
    out_t exp, got;
    #1;
    for (int c = 0; c < NCFG; c++) begin
      exp = model_out(c);
      got = {stall_pc[c], stall_if_id[c], bubble_id_ex[c], flush_if_id[c], flush_id_ex[c],
             flush_ex_mem[c], fwd_a[c], fwd_b[c], halted[c]};
      check_output($sformatf("cfg%0d_out", c), 32'(got), 32'(exp));
      check_output($sformatf("cfg%0d_ldfwd", c),
                   32'((got.fa == 2'b01 || got.fb == 2'b01) && pipe[c][1].mrd), 32'd0);
      obs[c] = got;
      model_step(c, exp);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_id(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                        input int dst, input bit wr, input bit mrd);
    id_valid = v; id_rs = AW'(rs); id_use_rs = urs; id_rt = AW'(rt); id_use_rt = urt;
    id_dst = AW'(dst); id_reg_wr = wr; id_mem_rd = mrd;
  endtask

  task automatic set_idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    id_jump = 0; br_taken_mem = 0; exc_ex = 0; exc_clear = 0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1; apply_stimulus();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    set_idle();
    for (int c = 0; c < NCFG; c++) begin
      for (int k = 0; k < 3; k++) pipe[c][k] = empty_instr();
      in_halt[c] = 0;
      nstall[c] = 0;
    end
    @(negedge clk);
    apply_stimulus();
    apply_stimulus();
    check_output("reset_outs", 32'(obs[0]), 32'd0);
    reset = 0;

    // add r3,r1,r2 then add r4,r3,r1 held in ID
    set_id(1, 1, 1, 2, 1, 3, 1, 0); apply_stimulus();
    set_id(1, 3, 1, 1, 1, 4, 1, 0);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus();
      for (int c = 0; c < NCFG; c++) nstall[c] += int'(obs[c].spc);
      if (i == 0) check_output("fwd_nostall", 32'(obs[0].spc), 32'd0);
      if (i == 1) check_output("fwd_mem_a", 32'(obs[0].fa), 32'd1);
    end
    check_output("raw_stalls_wt0", 32'(nstall[1]), 32'd3);
    check_output("raw_stalls_wt1", 32'(nstall[2]), 32'd2);
    set_idle();
    for (int i = 0; i < 3; i++) apply_stimulus();

    // lw r2,0(r0) then add r5,r2,r1
    do_reset();
    set_id(1, 0, 1, 0, 0, 2, 1, 1); apply_stimulus();
    set_id(1, 2, 1, 1, 1, 5, 1, 0); apply_stimulus();
    check_output("lu_stall", 32'({obs[0].spc, obs[0].sif, obs[0].bub}), 32'h7);
    apply_stimulus();
    check_output("lu_release", 32'(obs[0].spc), 32'd0);
    set_idle(); apply_stimulus();
    check_output("lu_fwd_wb", 32'(obs[0].fa), 32'd2);

    // load-use with a taken branch in the same cycle
    do_reset();
    set_id(1, 0, 1, 0, 0, 2, 1, 1); apply_stimulus();
    set_id(1, 2, 1, 1, 1, 5, 1, 0); br_taken_mem = 1; apply_stimulus();
    check_output("br_flush", 32'({obs[0].fif, obs[0].fie, obs[0].fem, obs[0].spc}), 32'he);
    br_taken_mem = 0; apply_stimulus();
    check_output("br_slots_empty", 32'(obs[1].spc), 32'd0);

    // exception, HALT hold, clear
    do_reset();
    set_id(1, 1, 1, 2, 1, 3, 1, 0); apply_stimulus();
    set_idle(); exc_ex = 1; apply_stimulus();
    check_output("exc_flush", 32'({obs[0].fem, obs[0].hlt}), 32'h2);
    exc_ex = 0;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus();
      check_output("halt_hold", 32'({obs[0].hlt, obs[0].spc, obs[0].fem}), 32'h6);
    end
    exc_clear = 1; apply_stimulus();
    check_output("halt_clear_cyc", 32'(obs[0].hlt), 32'd1);
    exc_clear = 0; apply_stimulus();
    check_output("run_after_clear", 32'(obs[0].hlt), 32'd0);

    // writes to r0 never create a hazard
    do_reset();
    set_id(1, 1, 1, 2, 1, 0, 1, 0); apply_stimulus();
    set_id(1, 0, 1, 0, 1, 6, 1, 0); apply_stimulus();
    check_output("r0_nostall", 32'(obs[1].spc), 32'd0);
    set_idle(); apply_stimulus();
    check_output("r0_nofwd", 32'(obs[0].fa), 32'd0);

    // reset asserted while halted
    set_id(1, 1, 1, 2, 1, 3, 1, 0); apply_stimulus();
    set_idle(); exc_ex = 1; apply_stimulus();
    exc_ex = 0; apply_stimulus();
    check_output("halt_before_rst", 32'(obs[2].hlt), 32'd1);
    reset = 1; apply_stimulus();
    check_output("rst_in_halt", 32'({obs[0], obs[1], obs[2]}), 32'd0);
    reset = 0; apply_stimulus();
    check_output("run_after_rst", 32'(obs[0].hlt), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(0, 63) == 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs        = AW'($urandom_range(0, 7));
      id_rt        = AW'($urandom_range(0, 7));
      id_use_rs    = ($urandom_range(0, 3) != 0);
      id_use_rt    = ($urandom_range(0, 1) != 0);
      id_dst       = AW'($urandom_range(0, 7));
      id_reg_wr    = ($urandom_range(0, 3) != 0);
      id_mem_rd    = ($urandom_range(0, 2) == 0);
      id_jump      = ($urandom_range(0, 7) == 0);
      br_taken_mem = ($urandom_range(0, 9) == 0);
      exc_ex       = ($urandom_range(0, 11) == 0);
      exc_clear    = ($urandom_range(0, 3) == 0);
      apply_stimulus();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
